// File: rtl/grid_clear_ctrl_pkg.sv
// Shared types and constants for the grid line-clear controller.
// The score table is only referenced when GRID_CLEAR_SCORE_EN is defined.
package grid_clear_ctrl_pkg;

  localparam int GRID_ROWS_DEF = 20;
  localparam int GRID_COLS_DEF = 10;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    SHIFT_RD,
    SHIFT_WR,
    CLR_TOP,
    DONE
  } state_t;

  localparam logic [31:0] PTS_0 = 32'd0;
  localparam logic [31:0] PTS_1 = 32'd40;
  localparam logic [31:0] PTS_2 = 32'd100;
  localparam logic [31:0] PTS_3 = 32'd300;
  localparam logic [31:0] PTS_4 = 32'd1200;

  function automatic logic [31:0] line_points(input logic [4:0] n);
    case (n)
      5'd0:    line_points = PTS_0;
      5'd1:    line_points = PTS_1;
      5'd2:    line_points = PTS_2;
      5'd3:    line_points = PTS_3;
      default: line_points = PTS_4;
    endcase
  endfunction

endpackage

// File: rtl/grid_clear_ctrl_if.sv
// Single-port grid RAM bus: the controller is master, the RAM is slave.
interface grid_clear_ctrl_if #(
  parameter int ADDRESS_WIDTH = 12,
  parameter int DATA_WIDTH    = 32
) ();
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic                     mem_wEn;
  logic [DATA_WIDTH-1:0]    mem_dataIn;
  logic [DATA_WIDTH-1:0]    mem_dataOut;

  modport master (output mem_addr, output mem_wEn, output mem_dataIn, input mem_dataOut);
  modport slave  (input mem_addr, input mem_wEn, input mem_dataIn, output mem_dataOut);
endinterface

// File: rtl/grid_addr_gen.sv
// Maps a (row, col) cell coordinate to its grid RAM word address.
module grid_addr_gen #(
  parameter int ADDRESS_WIDTH = 12,
  parameter int GRID_COLS     = 10,
  parameter int BASE_ADDR     = 0,
  parameter int RW            = 5,
  parameter int CW            = 4
) (
  input  logic [RW-1:0]            row,
  input  logic [CW-1:0]            col,
  output logic [ADDRESS_WIDTH-1:0] addr
);

  assign addr = ADDRESS_WIDTH'(BASE_ADDR)
              + ADDRESS_WIDTH'(row) * ADDRESS_WIDTH'(GRID_COLS)
              + ADDRESS_WIDTH'(col);

endmodule

// File: rtl/grid_clear_ctrl.sv
// Scans the grid bottom-up, removes full rows by shifting everything above down one row.
// Define GRID_CLEAR_SCORE_EN to build the score accumulator; otherwise score is tied to 0.
//
// state    | meaning
// IDLE     | waiting for start, RAM port released
// SCAN     | reading the current row one cell per cycle, looking for a zero cell
// SHIFT_RD | reading cell (dst-1, c)
// SHIFT_WR | writing that value to (dst, c)
// CLR_TOP  | writing zeros across row 0
// DONE     | one-cycle completion pulse
module grid_clear_ctrl
  import grid_clear_ctrl_pkg::*;
#(
  parameter int GRID_ROWS     = GRID_ROWS_DEF,
  parameter int GRID_COLS     = GRID_COLS_DEF,
  parameter int BASE_ADDR     = 0,
  parameter int ADDRESS_WIDTH = 12,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [4:0]          lines_cleared,
  output logic [31:0]         score,
  grid_clear_ctrl_if.master   mem
);

  localparam int RW = (GRID_ROWS > 1) ? $clog2(GRID_ROWS) : 1;
  localparam int CW = (GRID_COLS > 1) ? $clog2(GRID_COLS) : 1;
  localparam logic [RW-1:0] ROW_LAST = RW'(GRID_ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(GRID_COLS - 1);

  state_t          state;
  logic [RW-1:0]   row, dst, a_row;
  logic [CW-1:0]   a_col, chk;
  logic            pend;
  logic [4:0]      cnt;
  logic [ADDRESS_WIDTH-1:0] addr_w;

  // a_row/a_col always name the cell on the bus, so the address stays in range
  grid_addr_gen #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH), .GRID_COLS(GRID_COLS), .BASE_ADDR(BASE_ADDR),
    .RW(RW), .CW(CW)
  ) u_addr (
    .row (a_row),
    .col (a_col),
    .addr(addr_w)
  );

  assign mem.mem_addr   = addr_w;
  assign mem.mem_wEn    = (state == SHIFT_WR) || (state == CLR_TOP);
  assign mem.mem_dataIn = (state == SHIFT_WR) ? mem.mem_dataOut : '0;
  assign busy           = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      row           <= '0;
      dst           <= '0;
      a_row         <= '0;
      a_col         <= '0;
      chk           <= '0;
      pend          <= 1'b0;
      cnt           <= '0;
      done          <= 1'b0;
      lines_cleared <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= SCAN;
            row   <= ROW_LAST;
            a_row <= ROW_LAST;
            a_col <= '0;
            chk   <= '0;
            pend  <= 1'b0;
            cnt   <= '0;
          end
        end
        SCAN: begin
          // pend=0 on the first cycle of a row: the column-0 read is still in flight
          if (!pend) begin
            pend <= 1'b1;
            if (a_col != COL_LAST) a_col <= a_col + 1'b1;
          end else if (mem.mem_dataOut == '0) begin
            if (row == '0) begin
              state         <= DONE;
              done          <= 1'b1;
              lines_cleared <= cnt;
              a_row         <= '0;
              a_col         <= '0;
            end else begin
              row   <= row - 1'b1;
              a_row <= row - 1'b1;
              a_col <= '0;
              chk   <= '0;
              pend  <= 1'b0;
            end
          end else if (chk == COL_LAST) begin
            cnt   <= cnt + 5'd1;
            dst   <= row;
            a_col <= '0;
            if (row == '0) begin
              state <= CLR_TOP;
              a_row <= '0;
            end else begin
              state <= SHIFT_RD;
              a_row <= row - 1'b1;
            end
          end else begin
            chk <= chk + 1'b1;
            if (a_col != COL_LAST) a_col <= a_col + 1'b1;
          end
        end
        SHIFT_RD: begin
          state <= SHIFT_WR;
          a_row <= dst;
        end
        SHIFT_WR: begin
          if (a_col != COL_LAST) begin
            state <= SHIFT_RD;
            a_row <= dst - 1'b1;
            a_col <= a_col + 1'b1;
          end else if (dst == RW'(1)) begin
            state <= CLR_TOP;
            a_row <= '0;
            a_col <= '0;
          end else begin
            state <= SHIFT_RD;
            dst   <= dst - 1'b1;
            a_row <= dst - RW'(2);
            a_col <= '0;
          end
        end
        CLR_TOP: begin
          // rescan the same row index: it now holds what used to be above it
          if (a_col == COL_LAST) begin
            state <= SCAN;
            a_row <= row;
            a_col <= '0;
            chk   <= '0;
            pend  <= 1'b0;
          end else begin
            a_col <= a_col + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GRID_CLEAR_SCORE_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      score <= '0;
    end else if (state == DONE) begin
      score <= score + line_points(cnt);
    end
  end
`else
  assign score = '0;
`endif

endmodule

// File: tb/tb_grid_clear_ctrl.sv
// Directed self-checking bench for grid_clear_ctrl with a behavioural synchronous grid RAM.
module tb_grid_clear_ctrl;
  import grid_clear_ctrl_pkg::*;

  localparam int AW    = 12;
  localparam int DW    = 32;
  localparam int CELLS = 200;
`ifdef GRID_CLEAR_SCORE_EN
  localparam bit SCORE_EN = 1'b1;
`else
  localparam bit SCORE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done;
  logic [4:0]  lines_cleared;
  logic [31:0] score;

  grid_clear_ctrl_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) mem ();

  grid_clear_ctrl #(
    .GRID_ROWS(20), .GRID_COLS(10), .BASE_ADDR(0), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .lines_cleared(lines_cleared),
    .score        (score),
    .mem          (mem)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] ram [0:CELLS-1];
  logic          tb_we = 1'b0;
  logic [7:0]    tb_addr = '0;
  logic [DW-1:0] tb_data = '0;
  logic          in_rng;
  assign in_rng = (mem.mem_addr < AW'(CELLS));

  always @(posedge clk) begin
    if (tb_we) ram[tb_addr] <= tb_data;
    else if (mem.mem_wEn && in_rng) ram[mem.mem_addr[7:0]] <= mem.mem_dataIn;
    mem.mem_dataOut <= in_rng ? ram[mem.mem_addr[7:0]] : '0;
  end

  int wr_cnt = 0, done_cnt = 0, addr_bad = 0;
  always @(posedge clk) begin
    if (mem.mem_wEn) wr_cnt++;
    if (done) done_cnt++;
    if (busy && !in_rng) addr_bad++;
  end

  int passes = 0, checks = 0;
  logic [31:0] exp_score = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic clear_grid();
    @(negedge clk);
    tb_we = 1'b1;
    for (int a = 0; a < CELLS; a++) begin
      tb_addr = 8'(a);
      tb_data = '0;
      @(negedge clk);
    end
    tb_we = 1'b0;
  endtask

  task automatic fill_row(input int r, input logic [DW-1:0] v);
    @(negedge clk);
    tb_we = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tb_addr = 8'(r * 10 + c);
      tb_data = v;
      @(negedge clk);
    end
    tb_we = 1'b0;
  endtask

  task automatic set_cell(input int a, input logic [DW-1:0] v);
    @(negedge clk);
    tb_we = 1'b1;
    tb_addr = 8'(a);
    tb_data = v;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  function automatic int nonzero_cells();
    int n = 0;
    for (int a = 0; a < CELLS; a++) if (ram[a] != '0) n++;
    return n;
  endfunction

  task automatic start_pass();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // lat counts clock edges from the one that samples start to the one that raises done
  task automatic wait_done(output int lat);
    lat = 1;
    while (done !== 1'b1 && lat < 5000) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("done_seen", 64'(done), 64'd1);
    @(posedge clk);
    #1;
  endtask

  int lat, w0, d0, n;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_lines", 64'(lines_cleared), 64'd0);
    check("rst_score", 64'(score), 64'd0);
    check("rst_wen", 64'(mem.mem_wEn), 64'd0);
    check("rst_addr", 64'(mem.mem_addr), 64'd0);
    check("rst_din", 64'(mem.mem_dataIn), 64'd0);
    @(negedge clk) reset_n = 1'b1;

    // empty grid
    clear_grid();
    w0 = wr_cnt;
    start_pass();
    check("empty_busy", 64'(busy), 64'd1);
    wait_done(lat);
    check("empty_latency", 64'(lat), 64'd41);
    check("empty_lines", 64'(lines_cleared), 64'd0);
    check("empty_writes", 64'(wr_cnt - w0), 64'd0);
    check("empty_idle_busy", 64'(busy), 64'd0);
    check("empty_score", 64'(score), 64'(exp_score));

    // bottom row full
    clear_grid();
    fill_row(19, 32'd1);
    start_pass();
    wait_done(lat);
    exp_score = exp_score + (SCORE_EN ? 32'd40 : 32'd0);
    check("r19_lines", 64'(lines_cleared), 64'd1);
    check("r19_nonzero", 64'(nonzero_cells()), 64'd0);
    check("r19_score", 64'(score), 64'(exp_score));

    // four full rows with a single marker cell above them
    clear_grid();
    for (int r = 16; r < 20; r++) fill_row(r, 32'hA5);
    set_cell(150, 32'd5);
    start_pass();
    wait_done(lat);
    exp_score = exp_score + (SCORE_EN ? 32'd1200 : 32'd0);
    check("tetris_lines", 64'(lines_cleared), 64'd4);
    check("tetris_cell190", 64'(ram[190]), 64'd5);
    check("tetris_nonzero", 64'(nonzero_cells()), 64'd1);
    check("tetris_score", 64'(score), 64'(exp_score));

    // full rows split by a partial row
    clear_grid();
    fill_row(17, 32'd3);
    fill_row(19, 32'd9);
    set_cell(181, 32'd7);
    start_pass();
    wait_done(lat);
    exp_score = exp_score + (SCORE_EN ? 32'd100 : 32'd0);
    check("split_lines", 64'(lines_cleared), 64'd2);
    check("split_cell191", 64'(ram[191]), 64'd7);
    check("split_nonzero", 64'(nonzero_cells()), 64'd1);
    check("split_score", 64'(score), 64'(exp_score));

    // second start mid-pass must be ignored
    clear_grid();
    fill_row(19, 32'd1);
    d0 = done_cnt;
    start_pass();
    repeat (4) @(posedge clk);
    start_pass();
    wait_done(lat);
    repeat (30) @(posedge clk);
    #1;
    exp_score = exp_score + (SCORE_EN ? 32'd40 : 32'd0);
    check("restart_done_pulses", 64'(done_cnt - d0), 64'd1);
    check("restart_lines", 64'(lines_cleared), 64'd1);
    check("restart_nonzero", 64'(nonzero_cells()), 64'd0);
    check("restart_score", 64'(score), 64'(exp_score));
    check("restart_idle", 64'(busy), 64'd0);

    // reset while writing during the shift
    clear_grid();
    fill_row(19, 32'd1);
    d0 = done_cnt;
    start_pass();
    n = 0;
    while (mem.mem_wEn !== 1'b1 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("reach_shift_wr", 64'(mem.mem_wEn), 64'd1);
    reset_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_wen", 64'(mem.mem_wEn), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_lines", 64'(lines_cleared), 64'd0);
    check("midrst_score", 64'(score), 64'd0);
    exp_score = '0;
    @(negedge clk) reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("midrst_no_done", 64'(done_cnt - d0), 64'd0);

    clear_grid();
    fill_row(19, 32'd2);
    d0 = done_cnt;
    start_pass();
    wait_done(lat);
    exp_score = exp_score + (SCORE_EN ? 32'd40 : 32'd0);
    check("post_rst_lines", 64'(lines_cleared), 64'd1);
    check("post_rst_nonzero", 64'(nonzero_cells()), 64'd0);
    check("post_rst_score", 64'(score), 64'(exp_score));
    check("post_rst_done_pulses", 64'(done_cnt - d0), 64'd1);
    check("addr_range", 64'(addr_bad), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
